// File: rtl/pdu_run_ctrl_if.sv
// Board/CPU-facing bundle for the PDU run-control sequencer.
// Pure wiring, no latency.
// No backpressure: buttons and CPU status are levels, outputs are levels/pulses.
interface pdu_run_ctrl_if #(
  parameter int AW    = 32,
  parameter int CHK_W = 8
);
  // raw buttons
  logic             step;
  logic             cont;
  logic             chk;
  logic             ent;
  // CPU status and breakpoint setup
  logic [AW-1:0]    pc;
  logic [AW-1:0]    bp_addr;
  logic             bp_en;
  logic             io_in_req;
  logic             io_out_vld;
  // run-control outputs
  logic             cpu_ce;
  logic             pause;
  logic             ent_ack;
  logic             chk_mode;
  logic [CHK_W-1:0] chk_addr;
  logic [1:0]       state;

  // board / CPU side drives buttons and status, observes control
  modport master (
    output step, cont, chk, ent, pc, bp_addr, bp_en, io_in_req, io_out_vld,
    input  cpu_ce, pause, ent_ack, chk_mode, chk_addr, state
  );

  // sequencer side
  modport slave (
    input  step, cont, chk, ent, pc, bp_addr, bp_en, io_in_req, io_out_vld,
    output cpu_ce, pause, ent_ack, chk_mode, chk_addr, state
  );
endinterface

// File: rtl/pdu_run_ctrl.sv
// Run-control sequencer: debounces buttons and gates the single-cycle CPU clock enable.
// Button press acts DB_CYCLES+1 edges after first high sample; cpu_ce is combinational in RUN.
// No backpressure: CPU stalls only through cpu_ce; I/O waits hold until ent or cont.
module pdu_run_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int AW        = 32,
  parameter int CHK_W     = 8
) (
  input logic            i_clk,
  input logic            i_rstn,
  pdu_run_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);
  localparam logic [CW-1:0] DB_ARM = CW'(DB_CYCLES - 1);

  // button index order within the debounce vectors
  localparam int B_STEP = 0;
  localparam int B_CONT = 1;
  localparam int B_CHK  = 2;
  localparam int B_ENT  = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STEP    = 2'd1,
    S_RUN     = 2'd2,
    S_WAIT_IO = 2'd3
  } state_t;

  logic [3:0]       w_raw;
  logic [CW-1:0]    r_db_cnt [4];
  logic [3:0]       r_pls;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_first_run;
  logic             w_first_run_nxt;
  logic             r_ent_ack;
  logic             w_ent_ack_nxt;
  logic             r_pause;
  logic             r_chk_mode;
  logic [CHK_W-1:0] r_chk_addr;
  logic             w_cpu_ce;
  logic             w_stop;
  logic             w_bp_hit;
  logic [AW-1:0]    w_pc;
  logic [AW-1:0]    w_bp_addr;

  assign w_raw     = {bus.ent, bus.chk, bus.cont, bus.step};
  assign w_pc      = bus.pc;
  assign w_bp_addr = bus.bp_addr;

  // The breakpoint is masked on the first RUN cycle so resuming at bp_addr executes it.
  assign w_bp_hit = bus.bp_en && (w_pc == w_bp_addr) && !r_first_run;

  // Debounce: saturating run-length counter per button; one pulse when it reaches DB_CYCLES.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < 4; i++) begin
        r_db_cnt[i] <= '0;
      end
      r_pls <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!w_raw[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] != DB_MAX) begin
          r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
        end
        r_pls[i] <= w_raw[i] && (r_db_cnt[i] == DB_ARM);
      end
    end
  end

  // Next-state and clock-enable decode; cont always has top priority.
  always_comb begin
    w_state_nxt     = r_state;
    w_first_run_nxt = r_first_run;
    w_ent_ack_nxt   = 1'b0;
    w_cpu_ce        = 1'b0;
    w_stop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pls[B_CONT]) begin
          w_state_nxt     = S_RUN;
          w_first_run_nxt = 1'b1;
        end else if (r_pls[B_STEP]) begin
          w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        w_cpu_ce    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        w_first_run_nxt = 1'b0;
        w_stop          = r_pls[B_CONT] | w_bp_hit | bus.io_in_req;
        w_cpu_ce        = !w_stop;
        if (r_pls[B_CONT] || w_bp_hit) begin
          w_state_nxt = S_IDLE;
        end else if (bus.io_in_req) begin
          w_state_nxt = S_WAIT_IO;
        end else if (bus.io_out_vld) begin
          // the write completes this cycle, then stop so the user can see it
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_IO: begin
        if (r_pls[B_CONT]) begin
          w_state_nxt = S_IDLE;
        end else if (r_pls[B_ENT]) begin
          w_state_nxt     = S_RUN;
          w_first_run_nxt = 1'b0;
          w_ent_ack_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; pause is registered alongside state so it never glitches.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_first_run <= 1'b0;
      r_ent_ack   <= 1'b0;
      r_pause     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_first_run <= w_first_run_nxt;
      r_ent_ack   <= w_ent_ack_nxt;
      r_pause     <= (w_state_nxt != S_RUN);
    end
  end

  // Check-mode index: advances on a lone chk press in IDLE, display drops out on leaving IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_chk_mode <= 1'b0;
      r_chk_addr <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_state_nxt != S_IDLE) begin
        r_chk_mode <= 1'b0;
      end else if (r_pls[B_CHK]) begin
        r_chk_mode <= 1'b1;
        r_chk_addr <= r_chk_addr + CHK_W'(1);
      end
    end
  end

  assign bus.cpu_ce   = w_cpu_ce;
  assign bus.pause    = r_pause;
  assign bus.ent_ack  = r_ent_ack;
  assign bus.chk_mode = r_chk_mode;
  assign bus.chk_addr = r_chk_addr;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_pdu_run_ctrl.sv
// Directed bench for pdu_run_ctrl: expectations queued by stimulus, compared by a negedge monitor.
// Each expectation names the cycle window it applies to.
// Inputs change 1 time unit after the rising edge.
module tb_pdu_run_ctrl;

  localparam int SIG_STATE = 0;
  localparam int SIG_CE    = 1;
  localparam int SIG_PAUSE = 2;
  localparam int SIG_ACK   = 3;
  localparam int SIG_CMODE = 4;
  localparam int SIG_CADDR = 5;

  localparam logic [3:0] M_STEP = 4'b0001;
  localparam logic [3:0] M_CONT = 4'b0010;
  localparam logic [3:0] M_CHK  = 4'b0100;
  localparam logic [3:0] M_ENT  = 4'b1000;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  logic        clk;
  logic        rstn;
  int          cyc;
  int          checks;
  int          failures;
  exp_t        sb[$];
  logic        pc_ld;
  logic [31:0] pc_ld_val;

  pdu_run_ctrl_if #(.AW(32), .CHK_W(2)) bus ();

  pdu_run_ctrl #(.DB_CYCLES(4), .AW(32), .CHK_W(2)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // simple CPU model: PC advances one instruction per enabled cycle
  always @(posedge clk) begin
    if (pc_ld) bus.pc <= pc_ld_val;
    else if (bus.cpu_ce) bus.pc <= bus.pc + 32'd4;
  end

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      SIG_STATE: return {30'd0, bus.state};
      SIG_CE:    return {31'd0, bus.cpu_ce};
      SIG_PAUSE: return {31'd0, bus.pause};
      SIG_ACK:   return {31'd0, bus.ent_ack};
      SIG_CMODE: return {31'd0, bus.chk_mode};
      default:   return {30'd0, bus.chk_addr};
    endcase
  endfunction

  // monitor: compare every expectation due in the current cycle window
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [31:0] act;
        act = sample(sb[i].sig);
        checks++;
        if (sb[i].cyc < cyc || act !== sb[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%0h expected=%0h", sb[i].nm, sb[i].cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int off, input int sig, input logic [31:0] val, input string nm);
    exp_t e;
    e.cyc = cyc + off;
    e.sig = sig;
    e.val = val;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic set_btn(input logic [3:0] m);
    bus.step = m[0];
    bus.cont = m[1];
    bus.chk  = m[2];
    bus.ent  = m[3];
  endtask

  // hold buttons 4 edges; on return the press pulse is visible in the current window
  task automatic press(input logic [3:0] m);
    set_btn(m);
    repeat (4) tick();
    set_btn(4'b0000);
  endtask

  initial begin
    logic [1:0] chk_seq [5];
    chk_seq[0] = 2'd1; chk_seq[1] = 2'd2; chk_seq[2] = 2'd3; chk_seq[3] = 2'd0; chk_seq[4] = 2'd1;
    cyc = 0; checks = 0; failures = 0;
    rstn = 1'b0;
    pc_ld = 1'b1; pc_ld_val = 32'h0000_3000;
    set_btn(4'b0000);
    bus.bp_addr = 32'h0000_3010; bus.bp_en = 1'b0;
    bus.io_in_req = 1'b0; bus.io_out_vld = 1'b0;

    // reset state
    tick(); tick();
    checks++;
    if (bus.state !== 2'd0) begin
      failures++;
      $display("FAIL direct_rst_state actual=%0h expected=0", bus.state);
    end
    checks++;
    if (bus.cpu_ce !== 1'b0) begin
      failures++;
      $display("FAIL direct_rst_ce actual=%0h expected=0", bus.cpu_ce);
    end
    checks++;
    if (bus.pause !== 1'b1) begin
      failures++;
      $display("FAIL direct_rst_pause actual=%0h expected=1", bus.pause);
    end
    expect_at(0, SIG_STATE, 0, "rst_state");
    expect_at(0, SIG_CE,    0, "rst_ce");
    expect_at(0, SIG_PAUSE, 1, "rst_pause");
    expect_at(0, SIG_ACK,   0, "rst_ack");
    expect_at(0, SIG_CMODE, 0, "rst_cmode");
    expect_at(0, SIG_CADDR, 0, "rst_caddr");
    rstn = 1'b1;

    // 3-cycle press is too short
    set_btn(M_STEP);
    repeat (3) tick();
    set_btn(4'b0000);
    for (int k = 0; k < 4; k++) expect_at(k, SIG_STATE, 0, "short_press_idle");
    repeat (4) tick();

    // full press: one STEP cycle with ce, pause stays high
    press(M_STEP);
    expect_at(0, SIG_STATE, 0, "step_pulse_idle");
    expect_at(1, SIG_STATE, 1, "step_state");
    expect_at(1, SIG_CE,    1, "step_ce");
    expect_at(1, SIG_PAUSE, 1, "step_pause");
    expect_at(2, SIG_STATE, 0, "step_back_idle");
    expect_at(2, SIG_CE,    0, "step_ce_off");
    tick(); tick(); tick();

    // run to breakpoint at 0x3010
    bus.bp_en = 1'b1;
    pc_ld = 1'b0;
    press(M_CONT);
    for (int k = 1; k <= 4; k++) begin
      expect_at(k, SIG_STATE, 2, "bp_run_state");
      expect_at(k, SIG_CE,    1, "bp_run_ce");
      expect_at(k, SIG_PAUSE, 0, "bp_run_pause");
    end
    expect_at(5, SIG_CE,    0, "bp_hit_ce");
    expect_at(6, SIG_STATE, 0, "bp_stop_state");
    expect_at(6, SIG_PAUSE, 1, "bp_stop_pause");
    expect_at(6, SIG_CE,    0, "bp_stop_ce");
    repeat (6) tick();

    // resume: instruction at bp executes, then input wait
    press(M_CONT);
    expect_at(1, SIG_CE,    1, "bp_resume_ce");
    expect_at(1, SIG_STATE, 2, "bp_resume_state");
    tick(); tick();
    bus.io_in_req = 1'b1;
    expect_at(0, SIG_CE,    0, "io_in_ce_same_cycle");
    expect_at(1, SIG_STATE, 3, "wait_io_state");
    expect_at(1, SIG_PAUSE, 1, "wait_io_pause");
    tick();
    bus.io_in_req = 1'b0;

    press(M_ENT);
    expect_at(0, SIG_ACK,   0, "ent_pulse_no_ack");
    expect_at(1, SIG_ACK,   1, "ent_ack");
    expect_at(1, SIG_STATE, 2, "ent_run_state");
    expect_at(1, SIG_CE,    1, "ent_run_ce");
    expect_at(2, SIG_ACK,   0, "ent_ack_once");
    tick(); tick();

    // output pause
    bus.io_out_vld = 1'b1;
    expect_at(0, SIG_CE,    1, "io_out_ce");
    expect_at(1, SIG_STATE, 0, "io_out_idle");
    expect_at(1, SIG_PAUSE, 1, "io_out_pause");
    tick();
    bus.io_out_vld = 1'b0;

    // check mode stepping with wrap
    for (int n = 0; n < 5; n++) begin
      press(M_CHK);
      expect_at(1, SIG_CMODE, 1, "chk_mode_on");
      expect_at(1, SIG_CADDR, {30'd0, chk_seq[n]}, "chk_addr_seq");
      tick();
    end
    press(M_STEP);
    expect_at(1, SIG_STATE, 1, "chk_then_step");
    expect_at(1, SIG_CMODE, 0, "chk_mode_clear");
    expect_at(1, SIG_CADDR, 1, "chk_addr_hold");
    tick(); tick();

    // cont beats step; reset aborts RUN
    press(M_CONT | M_STEP);
    expect_at(1, SIG_STATE, 2, "cont_beats_step");
    expect_at(1, SIG_CE,    1, "cont_beats_step_ce");
    tick(); tick();
    rstn = 1'b0;
    tick();
    expect_at(0, SIG_STATE, 0, "rst_mid_run_state");
    expect_at(0, SIG_CE,    0, "rst_mid_run_ce");
    expect_at(0, SIG_PAUSE, 1, "rst_mid_run_pause");
    expect_at(0, SIG_CADDR, 0, "rst_mid_run_caddr");
    rstn = 1'b1;
    tick();

    // long hold gives exactly one press
    set_btn(M_CHK);
    repeat (10) tick();
    set_btn(4'b0000);
    expect_at(0, SIG_CADDR, 1, "hold_single_pulse");
    expect_at(0, SIG_CMODE, 1, "hold_cmode");
    tick();

    // cont + ent together in WAIT_IO aborts without ack
    press(M_CONT);
    tick();
    bus.io_in_req = 1'b1;
    expect_at(0, SIG_CE,    0, "wait2_ce");
    expect_at(0, SIG_CMODE, 0, "run_clears_cmode");
    tick();
    bus.io_in_req = 1'b0;
    expect_at(0, SIG_STATE, 3, "wait2_state");
    press(M_CONT | M_ENT);
    expect_at(1, SIG_STATE, 0, "cont_ent_idle");
    expect_at(1, SIG_ACK,   0, "cont_ent_no_ack");
    expect_at(1, SIG_PAUSE, 1, "cont_ent_pause");
    expect_at(2, SIG_ACK,   0, "cont_ent_no_ack_late");
    repeat (4) tick();
    checks++;
    if (bus.state !== 2'd0) begin
      failures++;
      $display("FAIL direct_end_state actual=%0h expected=0", bus.state);
    end
    checks++;
    if (bus.ent_ack !== 1'b0) begin
      failures++;
      $display("FAIL direct_end_ack actual=%0h expected=0", bus.ent_ack);
    end
    checks++;
    if (bus.pause !== 1'b1) begin
      failures++;
      $display("FAIL direct_end_pause actual=%0h expected=1", bus.pause);
    end

    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s never compared expected=%0h", sb[0].nm, sb[0].val);
      void'(sb.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
